// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the saturating counter helpers used when training an entry.
package bp_pkg;

   localparam logic [1:0] CNT_SNT        = 2'b00;
   localparam logic [1:0] CNT_WNT        = 2'b01;
   localparam logic [1:0] CNT_WT         = 2'b10;
   localparam logic [1:0] CNT_ST         = 2'b11;
   localparam logic [1:0] CNT_INIT_ALLOC = CNT_WT;
   localparam logic [1:0] CNT_RESET      = CNT_WNT;

   function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
      return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/bp_btb_array.sv
// BTB storage: ENTRIES flop entries, combinational read for lookup and for the
// resolve path, one write port, and a single-cycle bulk invalidate.
module bp_btb_array
   import bp_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int ADDR_W  = 32,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = ADDR_W - IDX_W - 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush,
   input  logic [IDX_W-1:0]  lk_idx,
   output logic              lk_valid,
   output logic [TAG_W-1:0]  lk_tag,
   output logic [ADDR_W-1:0] lk_target,
   output logic [1:0]        lk_cnt,
   input  logic [IDX_W-1:0]  up_idx,
   output logic              up_valid,
   output logic [TAG_W-1:0]  up_tag,
   output logic [ADDR_W-1:0] up_target,
   output logic [1:0]        up_cnt,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [ADDR_W-1:0] wr_target,
   input  logic [1:0]        wr_cnt
);

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [ADDR_W-1:0] target;
      logic [1:0]        cnt;
   } entry_t;

   entry_t mem [ENTRIES];

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         entry_t ent;
         // Flush clears only valid; counters keep their learned bias.
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               ent <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_RESET};
            end else if (flush) begin
               ent.valid <= 1'b0;
            end else if (wr_en && wr_idx == IDX_W'(gi)) begin
               ent <= '{valid: 1'b1, tag: wr_tag, target: wr_target, cnt: wr_cnt};
            end
         end
         assign mem[gi] = ent;
      end
   endgenerate

   assign lk_valid  = mem[lk_idx].valid;
   assign lk_tag    = mem[lk_idx].tag;
   assign lk_target = mem[lk_idx].target;
   assign lk_cnt    = mem[lk_idx].cnt;
   assign up_valid  = mem[up_idx].valid;
   assign up_tag    = mem[up_idx].tag;
   assign up_target = mem[up_idx].target;
   assign up_cnt    = mem[up_idx].cnt;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB with 2-bit counters, optional gshare history,
// zero-latency lookup for IF and resolve-time training with perf counters.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 64,
   parameter int GHR_W   = 0,
   parameter int PERF_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] lookup_pc_i,
   output logic              predict_taken_o,
   output logic [ADDR_W-1:0] predict_target_o,
   output logic              predict_hit_o,
   input  logic              flush_all_i,
   input  logic              update_valid_i,
   input  logic [ADDR_W-1:0] update_pc_i,
   input  logic              update_taken_i,
   input  logic [ADDR_W-1:0] update_target_i,
   input  logic              update_pred_taken_i,
   input  logic [ADDR_W-1:0] update_pred_target_i,
   output logic              mispredict_o,
   output logic [PERF_W-1:0] branch_cnt_o,
   output logic [PERF_W-1:0] miss_cnt_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   logic [IDX_W-1:0] hist;

   generate
      if (GHR_W > 0) begin : g_ghr
         logic [GHR_W-1:0] ghr;
         logic [GHR_W:0]   shifted;
         assign shifted = {ghr, update_taken_i};
         // History advances only on resolved updates, never speculatively.
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i)              ghr <= '0;
            else if (flush_all_i)    ghr <= '0;
            else if (update_valid_i) ghr <= shifted[GHR_W-1:0];
         end
         assign hist = IDX_W'(ghr);
      end else begin : g_bimodal
         assign hist = '0;
      end
   endgenerate

   logic [IDX_W-1:0]  lk_idx, up_idx;
   logic [TAG_W-1:0]  lk_tag, up_tag, lk_tag_st, up_tag_st;
   logic              lk_valid, up_valid, up_hit;
   logic [ADDR_W-1:0] lk_target, up_target;
   logic [1:0]        lk_cnt, up_cnt;
   logic              wr_en;
   logic [1:0]        wr_cnt;
   logic [ADDR_W-1:0] wr_target;
   logic              mispredict;

   assign lk_idx = lookup_pc_i[IDX_W+1:2] ^ hist;
   assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
   assign up_idx = update_pc_i[IDX_W+1:2] ^ hist;
   assign up_tag = update_pc_i[ADDR_W-1:IDX_W+2];

   bp_btb_array #(
      .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .TAG_W(TAG_W)
   ) u_btb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush     (flush_all_i),
      .lk_idx    (lk_idx),
      .lk_valid  (lk_valid),
      .lk_tag    (lk_tag_st),
      .lk_target (lk_target),
      .lk_cnt    (lk_cnt),
      .up_idx    (up_idx),
      .up_valid  (up_valid),
      .up_tag    (up_tag_st),
      .up_target (up_target),
      .up_cnt    (up_cnt),
      .wr_en     (wr_en),
      .wr_idx    (up_idx),
      .wr_tag    (up_tag),
      .wr_target (wr_target),
      .wr_cnt    (wr_cnt)
   );

   assign predict_hit_o    = lk_valid && (lk_tag_st == lk_tag);
   assign predict_taken_o  = predict_hit_o && lk_cnt[1];
   assign predict_target_o = predict_taken_o ? lk_target : lookup_pc_i + ADDR_W'(4);

   // A not-taken miss leaves the table alone; a taken miss allocates.
   assign up_hit    = up_valid && (up_tag_st == up_tag);
   assign wr_en     = update_valid_i && (up_hit || update_taken_i);
   assign wr_cnt    = !up_hit ? CNT_INIT_ALLOC
                    : (update_taken_i ? sat_inc(up_cnt) : sat_dec(up_cnt));
   assign wr_target = update_taken_i ? update_target_i : up_target;

   assign mispredict = (update_pred_taken_i != update_taken_i) ||
                       (update_taken_i && (update_pred_target_i != update_target_i));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mispredict_o <= 1'b0;
         branch_cnt_o <= '0;
         miss_cnt_o   <= '0;
      end else begin
         mispredict_o <= update_valid_i && mispredict;
         if (update_valid_i && branch_cnt_o != '1)
            branch_cnt_o <= branch_cnt_o + PERF_W'(1);
         if (update_valid_i && mispredict && miss_cnt_o != '1)
            miss_cnt_o <= miss_cnt_o + PERF_W'(1);
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal instance and a gshare/4-bit-perf instance
// share stimulus and are checked every cycle against an array-based model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] lookup_pc = '0;
   logic        flush = 1'b0;
   logic        uv = 1'b0;
   logic [31:0] upc = '0;
   logic        ut = 1'b0;
   logic [31:0] utgt = '0;
   logic        ppt = 1'b0;
   logic [31:0] pptgt = '0;

   logic        hit0, taken0, mp0, hit1, taken1, mp1;
   logic [31:0] tgt0, tgt1, bc0, mc0;
   logic [3:0]  bc1, mc1;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   branch_predictor #(.ADDR_W(32), .ENTRIES(16), .GHR_W(0), .PERF_W(32)) dut0 (
      .clk_i(clk), .rst_i(rst_i), .lookup_pc_i(lookup_pc),
      .predict_taken_o(taken0), .predict_target_o(tgt0), .predict_hit_o(hit0),
      .flush_all_i(flush), .update_valid_i(uv), .update_pc_i(upc),
      .update_taken_i(ut), .update_target_i(utgt),
      .update_pred_taken_i(ppt), .update_pred_target_i(pptgt),
      .mispredict_o(mp0), .branch_cnt_o(bc0), .miss_cnt_o(mc0));

   branch_predictor #(.ADDR_W(32), .ENTRIES(16), .GHR_W(2), .PERF_W(4)) dut1 (
      .clk_i(clk), .rst_i(rst_i), .lookup_pc_i(lookup_pc),
      .predict_taken_o(taken1), .predict_target_o(tgt1), .predict_hit_o(hit1),
      .flush_all_i(flush), .update_valid_i(uv), .update_pc_i(upc),
      .update_taken_i(ut), .update_target_i(utgt),
      .update_pred_taken_i(ppt), .update_pred_target_i(pptgt),
      .mispredict_o(mp1), .branch_cnt_o(bc1), .miss_cnt_o(mc1));

   // Model state, per instance k (0: bimodal/32-bit perf, 1: gshare 2/4-bit perf)
   bit          m_valid [2][16];
   int unsigned m_tag   [2][16];
   logic [31:0] m_tgt   [2][16];
   int          m_cnt   [2][16];
   int          m_ghr   [2];
   longint unsigned m_b [2];
   longint unsigned m_m [2];
   bit          m_mp    [2];

   function automatic int ghr_bits(int k);  return (k == 0) ? 0 : 2;  endfunction
   function automatic int perf_bits(int k); return (k == 0) ? 32 : 4; endfunction

   function automatic int m_index(int k, logic [31:0] pc);
      return int'(pc[5:2]) ^ m_ghr[k];
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      else
         passed++;
   endtask

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) begin
            m_valid[k][i] = 1'b0;
            m_cnt[k][i]   = 1;
         end
         m_ghr[k] = 0; m_b[k] = 0; m_m[k] = 0; m_mp[k] = 1'b0;
      end
   endtask

   task automatic m_predict(int k, logic [31:0] pc, output bit h, output bit t,
                            output logic [31:0] tg);
      int i = m_index(k, pc);
      h  = m_valid[k][i] && (m_tag[k][i] == int'(pc[31:6]));
      t  = h && (m_cnt[k][i] >= 2);
      tg = t ? m_tgt[k][i] : pc + 32'd4;
   endtask

   task automatic m_update(int k);
      longint unsigned maxv = (64'd1 << perf_bits(k)) - 1;
      bit mis = (ppt != ut) || (ut && pptgt != utgt);
      int i = m_index(k, upc);
      m_mp[k] = uv && mis;
      if (uv && m_b[k] < maxv) m_b[k]++;
      if (uv && mis && m_m[k] < maxv) m_m[k]++;
      if (flush) begin
         for (int j = 0; j < 16; j++) m_valid[k][j] = 1'b0;
         m_ghr[k] = 0;
      end else if (uv) begin
         if (m_valid[k][i] && m_tag[k][i] == int'(upc[31:6])) begin
            m_cnt[k][i] = ut ? ((m_cnt[k][i] == 3) ? 3 : m_cnt[k][i] + 1)
                             : ((m_cnt[k][i] == 0) ? 0 : m_cnt[k][i] - 1);
            if (ut) m_tgt[k][i] = utgt;
         end else if (ut) begin
            m_valid[k][i] = 1'b1;
            m_tag[k][i]   = int'(upc[31:6]);
            m_tgt[k][i]   = utgt;
            m_cnt[k][i]   = 2;
         end
         if (ghr_bits(k) > 0)
            m_ghr[k] = ((m_ghr[k] << 1) | int'(ut)) & ((1 << ghr_bits(k)) - 1);
      end
   endtask

   task automatic cmp_comb();
      bit h, t; logic [31:0] tg;
      m_predict(0, lookup_pc, h, t, tg);
      chk("hit0", 64'(hit0), 64'(h));
      chk("taken0", 64'(taken0), 64'(t));
      chk("target0", 64'(tgt0), 64'(tg));
      m_predict(1, lookup_pc, h, t, tg);
      chk("hit1", 64'(hit1), 64'(h));
      chk("taken1", 64'(taken1), 64'(t));
      chk("target1", 64'(tgt1), 64'(tg));
   endtask

   task automatic cmp_regs();
      chk("mispredict0", 64'(mp0), 64'(m_mp[0]));
      chk("mispredict1", 64'(mp1), 64'(m_mp[1]));
      chk("branch_cnt0", 64'(bc0), m_b[0]);
      chk("miss_cnt0", 64'(mc0), m_m[0]);
      chk("branch_cnt1", 64'(bc1), m_b[1]);
      chk("miss_cnt1", 64'(mc1), m_m[1]);
   endtask

   // Called just after a falling edge: drive, check lookup, clock, check state.
   task automatic drive(logic [31:0] lpc, logic v, logic [31:0] pc, logic tk,
                        logic [31:0] tg, logic pt, logic [31:0] ptg, logic fl);
      lookup_pc = lpc; uv = v; upc = pc; ut = tk; utgt = tg;
      ppt = pt; pptgt = ptg; flush = fl;
      #1 cmp_comb();
   endtask

   task automatic clock();
      @(posedge clk);
      for (int k = 0; k < 2; k++) m_update(k);
      #1 cmp_regs();
      @(negedge clk);
   endtask

   task automatic look(logic [31:0] lpc);
      drive(lpc, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic upd(logic [31:0] pc, logic tk, logic [31:0] tg, logic pt,
                      logic [31:0] ptg, logic fl);
      drive(pc, 1'b1, pc, tk, tg, pt, ptg, fl);
      clock();
   endtask

   // Reset asserted mid-cycle with an update in flight; the update must vanish.
   task automatic do_reset();
      uv = 1'b1; ut = 1'b1; upc = 32'h40; utgt = 32'h500;
      #2 rst_i = 1'b0;
      #1 m_reset();
      chk("rst_mispredict", 64'(mp0 | mp1), 64'd0);
      chk("rst_counts", 64'(bc0 | mc0 | 32'(bc1) | 32'(mc1)), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b1; uv = 1'b0; ut = 1'b0; flush = 1'b0;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] p;
      if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFC;
      p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      return p;
   endfunction

   initial begin
      bit h, t; logic [31:0] tg, lpc, pc, ptg_r;
      logic tk, pt;
      m_reset();
      repeat (2) @(negedge clk);
      rst_i = 1'b1;

      // Reset state
      look(32'h40);
      chk("lit_reset_hit", 64'(hit0), 64'd0);
      chk("lit_reset_target", 64'(tgt0), 64'h44);
      chk("lit_reset_bcnt", 64'(bc0), 64'd0);
      clock();

      // Allocate then train down: 10 -> 01 -> 00 -> 00
      upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
      look(32'h40);
      chk("lit_alloc_hit", 64'(hit0), 64'd1);
      chk("lit_alloc_target", 64'(tgt0), 64'h100);
      clock();
      upd(32'h40, 1'b0, 32'h44, 1'b1, 32'h100, 1'b0);
      upd(32'h40, 1'b0, 32'h44, 1'b0, 32'h44, 1'b0);
      look(32'h40);
      chk("lit_trained_taken", 64'(taken0), 64'd0);
      chk("lit_trained_target", 64'(tgt0), 64'h44);
      clock();
      upd(32'h40, 1'b0, 32'h44, 1'b0, 32'h44, 1'b0);
      upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
      look(32'h40);
      chk("lit_sat_floor_taken", 64'(taken0), 64'd0);
      clock();

      // Alias on idx 0 with a different tag
      look(32'h80);
      chk("lit_alias_hit", 64'(hit0), 64'd0);
      clock();
      upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h84, 1'b0);
      look(32'h40);
      chk("lit_replaced_hit", 64'(hit0), 64'd0);
      clock();

      // Mispredict on wrong target
      do_reset();
      upd(32'h80, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0);
      chk("lit_mp", 64'(mp0), 64'd1);
      chk("lit_mp_miss_cnt", 64'(mc0), 64'd1);
      chk("lit_mp_branch_cnt", 64'(bc0), 64'd1);
      look(32'h80);
      clock();
      chk("lit_mp_one_cycle", 64'(mp0), 64'd0);

      // Flush beats a same-cycle allocate; stats still count it
      upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1);
      look(32'h40);
      chk("lit_flush_hit", 64'(hit0), 64'd0);
      chk("lit_flush_bcnt", 64'(bc0), 64'd2);
      clock();

      // Gshare: after two taken updates ghr=11, lookup 0x40 indexes entry 3
      do_reset();
      upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
      upd(32'h44, 1'b1, 32'h180, 1'b0, 32'h48, 1'b0);
      look(32'h40);
      chk("lit_gshare_hit", 64'(hit1), 64'd0);
      chk("lit_bimodal_hit", 64'(hit0), 64'd1);
      clock();

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            continue;
         end
         pc  = rand_pc();
         lpc = ($urandom_range(0, 9) < 3) ? pc : rand_pc();
         tk  = 1'($urandom_range(0, 1));
         tg  = 32'($urandom_range(1, 6)) << 7;
         if ($urandom_range(0, 1) == 1) begin
            m_predict(0, pc, h, t, tg);
            pt = t; ptg_r = tg;
            tg = 32'($urandom_range(1, 6)) << 7;
         end else begin
            pt = 1'($urandom_range(0, 1));
            ptg_r = 32'($urandom_range(1, 6)) << 7;
         end
         drive(lpc, 1'($urandom_range(0, 3) != 0), pc, tk, tg, pt, ptg_r,
               1'($urandom_range(0, 39) == 0));
         clock();
      end

      // Perf counter saturation at 4 bits
      do_reset();
      for (int n = 0; n < 20; n++)
         upd(rand_pc(), 1'($urandom_range(0, 1)), 32'h200, 1'b1, 32'h100, 1'b0);
      chk("lit_bcnt_sat", 64'(bc1), 64'd15);
      chk("lit_bcnt_wide", 64'(bc0), 64'd20);
      chk("lit_mcnt_sat", 64'(mc1), 64'd15);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
